// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, burst-locked sharing of one UART transmitter among NUM_REQ requesters.
// Optional watchdog abort is built in when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 3,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_en,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 arb_busy,
    output logic                 abort
);
    localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if ((2**IDX_W) < NUM_REQ || TIMEOUT > 65535) begin : g_param_check
        $error("uart_tx_arbiter: IDX_W too narrow for NUM_REQ or TIMEOUT exceeds 16 bits");
    end

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        WAIT_BUSY_HI,
        WAIT_BUSY_LO
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_q, rr_d, rr_next;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               last_q, last_d;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        cand;
    logic [7:0]         data_arr [NUM_REQ];
    logic [SEL_W-1:0]   gsel;
    logic               g_valid, g_last;
    logic               timeout;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign data_arr[i] = req_data[8*i +: 8];
    end

    assign gsel    = SEL_W'(gidx_q);
    assign g_valid = req_valid[gsel];
    assign g_last  = req_last[gsel];
    assign rr_next = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

    // First valid requester scanning upward from rr_q with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = 32'(rr_q) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!pick_found && req_valid[SEL_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        counting;

    assign counting = (state_q == FETCH) || (state_q == WAIT_BUSY_HI) || (state_q == WAIT_BUSY_LO);
    assign timeout  = counting && (cnt_q == 16'(TIMEOUT));

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && counting) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            rr_q      <= '0;
            tx_data_q <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            rr_q      <= rr_d;
            tx_data_q <= tx_data_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        rr_d      = rr_q;
        tx_data_d = tx_data_q;
        last_d    = last_q;
        case (state_q)
            IDLE: if (pick_found) begin
                grant_d = NUM_REQ'(1) << pick_idx;
                gidx_d  = pick_idx;
                state_d = FETCH;
            end
            FETCH: if (g_valid) begin
                tx_data_d = data_arr[gsel];
                last_d    = g_last;
                state_d   = START;
            end
            START:        state_d = WAIT_BUSY_HI;
            WAIT_BUSY_HI: if (tx_busy) state_d = WAIT_BUSY_LO;
            WAIT_BUSY_LO: if (!tx_busy) begin
                if (last_q) begin
                    grant_d = '0;
                    rr_d    = rr_next;
                    state_d = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog abort drops any byte being fetched and skips the stalled requester.
        if (timeout) begin
            state_d   = IDLE;
            grant_d   = '0;
            rr_d      = rr_next;
            tx_data_d = tx_data_q;
            last_d    = last_q;
        end
    end

    always_comb begin
        req_ready = '0;
        tx_en     = 1'b0;
        tx_start  = 1'b0;
        case (state_q)
            FETCH: req_ready = timeout ? '0 : grant_q;
            START: begin
                tx_en    = 1'b1;
                tx_start = 1'b1;
            end
            WAIT_BUSY_HI: begin
                tx_en    = !timeout;
                tx_start = !timeout;
            end
            WAIT_BUSY_LO: tx_en = !timeout;
            default: ;
        endcase
    end

    assign grant    = grant_q;
    assign tx_data  = tx_data_q;
    assign arb_busy = (state_q != IDLE);
    assign abort    = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: UART busy model at negedge, scoreboard of {grant, byte} frames.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready, grant;
    logic        tx_en, tx_start, tx_busy, arb_busy, abort;
    logic [7:0]  tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(2), .IDX_W(3), .TIMEOUT(65535)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .tx_en(tx_en), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .arb_busy(arb_busy), .abort(abort)
    );

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          hi_q[$];
    int busy_delay = 10;
    int busy_len = 8;
    int mstate = 0, mcnt = 0, hi_cnt = 0, en_err = 0, grant_jump = 0;
    logic [1:0] last_grant = '0;

    // UART model: captures a frame when tx_start is seen, raises busy busy_delay cycles later.
    always @(negedge clk) begin
        if (rst) begin
            tx_busy    = 1'b0;
            mstate     = 0;
            last_grant = '0;
        end else begin
            if (grant != 0 && last_grant != 0 && grant != last_grant) grant_jump++;
            last_grant = grant;
            case (mstate)
                0: if (tx_start) begin
                    got_q.push_back({6'b0, grant, tx_data});
                    hi_cnt = 1;
                    mcnt   = busy_delay;
                    mstate = 1;
                end
                1: begin
                    if (!tx_en) en_err++;
                    if (tx_start) hi_cnt++;
                    mcnt--;
                    if (mcnt == 0) begin tx_busy = 1'b1; mcnt = busy_len; mstate = 2; end
                end
                default: begin
                    if (!tx_en) en_err++;
                    if (tx_start) hi_cnt++;
                    mcnt--;
                    if (mcnt == 0) begin tx_busy = 1'b0; mstate = 0; hi_q.push_back(hi_cnt); end
                end
            endcase
        end
    end

    task automatic put_byte(input int r, input logic [7:0] d, input logic l);
        bit done = 0;
        req_data[8*r +: 8] = d;
        req_last[r]  = l;
        req_valid[r] = 1'b1;
        for (int k = 0; k < 3000 && !done; k++) begin
            if (req_ready[r]) begin @(posedge clk); done = 1; end
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL handshake req%0d byte %h: ready never seen, required within 3000 cycles", r, d);
        end
    endtask

    task automatic wait_idle(input int n, output bit ok);
        ok = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (got_q.size() >= n && hi_q.size() >= n && !arb_busy) begin ok = 1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        got_q.delete(); hi_q.delete(); exp_q.delete();
        en_err = 0; grant_jump = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({grant, req_ready, tx_en, tx_start, tx_data, arb_busy, abort} !== '0)
            $display("FAIL reset_values: got g=%b r=%b en=%b st=%b d=%h busy=%b ab=%b, required all 0",
                     grant, req_ready, tx_en, tx_start, tx_data, arb_busy, abort);
        else passed++;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        bit ok;
        busy_delay = 10; busy_len = 8;
        exp_q.push_back({6'b0, 2'b01, 8'hA5});
        put_byte(0, 8'hA5, 1'b1);
        wait_idle(1, ok);
        checks++; if (!ok) $display("FAIL single_done: frame not completed, got %0d frames, required 1", got_q.size()); else passed++;
        repeat (20) @(negedge clk);
        checks++; if (got_q.size() != 1) $display("FAIL single_count: got %0d frames, required 1", got_q.size()); else passed++;
        for (int i = 0; i < 1; i++) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            checks++; if (g !== e) $display("FAIL single_frame: got %h, required %h", g, e); else passed++;
        end
        checks++; if (hi_q.size() == 0 || hi_q[0] != 11) $display("FAIL single_start_hold: got %0d cycles, required 11", hi_q.size() ? hi_q[0] : -1); else passed++;
        checks++; if (grant !== 2'b00) $display("FAIL single_grant_idle: got %b, required 00", grant); else passed++;
        checks++; if (arb_busy !== 1'b0) $display("FAIL single_arb_busy: got %b, required 0", arb_busy); else passed++;
        checks++; if (en_err != 0) $display("FAIL single_tx_en: got %0d low samples during frame, required 0", en_err); else passed++;
        hi_q.delete();
    endtask

    task automatic test_burst_lock();
        bit ok;
        do_reset();
        busy_delay = 3; busy_len = 4;
        exp_q.push_back({6'b0, 2'b01, 8'h11});
        exp_q.push_back({6'b0, 2'b01, 8'h22});
        exp_q.push_back({6'b0, 2'b01, 8'h33});
        exp_q.push_back({6'b0, 2'b10, 8'h44});
        fork
            begin put_byte(0, 8'h11, 1'b0); put_byte(0, 8'h22, 1'b0); put_byte(0, 8'h33, 1'b1); end
            put_byte(1, 8'h44, 1'b1);
        join
        wait_idle(4, ok);
        repeat (10) @(negedge clk);
        checks++; if (got_q.size() != 4) $display("FAIL burst_count: got %0d frames, required 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            checks++; if (g !== e) $display("FAIL burst_frame%0d: got %h, required %h", i, g, e); else passed++;
        end
        checks++; if (grant_jump != 0) $display("FAIL burst_grant_toggle: got %0d direct owner changes, required 0", grant_jump); else passed++;
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        busy_delay = 2; busy_len = 3;
        exp_q.push_back({6'b0, 2'b01, 8'hA0});
        exp_q.push_back({6'b0, 2'b10, 8'hB0});
        exp_q.push_back({6'b0, 2'b01, 8'hA1});
        exp_q.push_back({6'b0, 2'b10, 8'hB1});
        fork
            begin put_byte(0, 8'hA0, 1'b1); put_byte(0, 8'hA1, 1'b1); end
            begin put_byte(1, 8'hB0, 1'b1); put_byte(1, 8'hB1, 1'b1); end
        join
        wait_idle(4, ok);
        checks++; if (!ok || got_q.size() != 4) $display("FAIL rr_count: got %0d frames, required 4", got_q.size()); else passed++;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            checks++; if (g !== e) $display("FAIL rr_frame%0d: got %h, required %h", i, g, e); else passed++;
        end
        hi_q.delete();
    endtask

    task automatic test_slow_busy();
        bit ok;
        busy_delay = 50; busy_len = 5; en_err = 0;
        exp_q.push_back({6'b0, 2'b01, 8'h5A});
        put_byte(0, 8'h5A, 1'b1);
        wait_idle(1, ok);
        repeat (20) @(negedge clk);
        checks++; if (!ok || got_q.size() != 1) $display("FAIL slow_count: got %0d frames, required 1", got_q.size()); else passed++;
        for (int i = 0; i < 1; i++) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            checks++; if (g !== e) $display("FAIL slow_frame: got %h, required %h", g, e); else passed++;
        end
        checks++; if (hi_q.size() == 0 || hi_q[0] != 51) $display("FAIL slow_start_hold: got %0d cycles, required 51", hi_q.size() ? hi_q[0] : -1); else passed++;
        checks++; if (en_err != 0) $display("FAIL slow_tx_en: got %0d low samples, required 0", en_err); else passed++;
        hi_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit seen = 0;
        busy_delay = 3; busy_len = 40;
        exp_q.push_back({6'b0, 2'b01, 8'hC3});
        put_byte(0, 8'hC3, 1'b1);
        for (int k = 0; k < 200 && !seen; k++) begin @(negedge clk); if (tx_busy) seen = 1; end
        checks++; if (!seen) $display("FAIL midrst_busy: tx_busy never rose, required within 200 cycles"); else passed++;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({grant, req_ready, tx_en, tx_start, tx_data, arb_busy, abort} !== '0)
            $display("FAIL midrst_values: got g=%b r=%b en=%b st=%b d=%h busy=%b ab=%b, required all 0",
                     grant, req_ready, tx_en, tx_start, tx_data, arb_busy, abort);
        else passed++;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        hi_q.delete();
        busy_len = 4;
        exp_q.push_back({6'b0, 2'b10, 8'h7E});
        @(negedge clk);
        put_byte(1, 8'h7E, 1'b1);
        wait_idle(2, ok);
        hi_q.delete();
        wait_idle(0, ok);
        checks++; if (got_q.size() != 2) $display("FAIL midrst_count: got %0d frames, required 2", got_q.size()); else passed++;
        for (int i = 0; i < 2; i++) begin
            logic [15:0] e, g;
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 16'hxxxx;
            checks++; if (g !== e) $display("FAIL midrst_frame%0d: got %h, required %h", i, g, e); else passed++;
        end
        checks++; if (grant !== 2'b00 || arb_busy !== 1'b0) $display("FAIL midrst_idle: got grant=%b busy=%b, required 00/0", grant, arb_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_burst_lock();
        test_round_robin();
        test_slow_busy();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
